br_outcome_buf: RTL

- Branch outcome buffer (BOB): in-order circular FIFO between the fetch-stage tournament predictor and the retire stage.
- At fetch, each predicted branch allocates an entry. The entry captures the predictor snapshot: branch PC, global history (bhr), local history (bht), choice-update enable and choice-update direction.
- At retire, the head entry is presented back to the predictor so it can do its non-speculative PHT/BHT/choice updates and bhr recovery. The entry is popped when the branch retires.
- The whole buffer is cleared on a retire-stage flush.

---
 rtl/br_outcome_buf.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/br_outcome_buf.sv
// ----------------------------------------------------------------------------
// br_outcome_buf - branch outcome buffer (BOB)
//
// In-order circular FIFO between the fetch-stage tournament predictor and the
// retire stage. Fetch allocates one entry per predicted branch, capturing the
// predictor snapshot. Retire sees the head entry combinationally, uses it for
// the non-speculative predictor updates and bhr recovery, and pops it when
// the branch retires. A retire flush empties the whole buffer.
//
// Parameters
//   DEPTH   number of entries (power of 2, >= 2)
//   PTR_W   log2(DEPTH)
//
// Ports
//   clock, reset_n          clock, async active-low reset
//   alloc_vld_i             allocate request from fetch
//   alloc_brpc_i/bhr_i/bht_i/chwe_i/chbrdir_i   snapshot to store
//   alloc_rdy_o             buffer not full
//   alloc_idx_o             index the next allocation receives (tail)
//   rt_pop_i                head branch retires
//   pipctl_flush_rt_i       retire flush, clears all entries
//   bob_valid_o             head entry valid (buffer not empty)
//   bob_brpc_o/bhr_o/bht_o/chwe_o/chbrdir_o     head snapshot (0 when empty)
//   bob_count_o             occupied entry count
//   bob_ovf_o, bob_udf_o    sticky overflow / underflow, cleared by reset only
// ----------------------------------------------------------------------------
module br_outcome_buf #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             alloc_vld_i,
    input  logic [63:0]      alloc_brpc_i,
    input  logic [11:0]      alloc_bhr_i,
    input  logic [9:0]       alloc_bht_i,
    input  logic             alloc_chwe_i,
    input  logic             alloc_chbrdir_i,
    output logic             alloc_rdy_o,
    output logic [PTR_W-1:0] alloc_idx_o,
    input  logic             rt_pop_i,
    input  logic             pipctl_flush_rt_i,
    output logic             bob_valid_o,
    output logic [63:0]      bob_brpc_o,
    output logic [11:0]      bob_bhr_o,
    output logic [9:0]       bob_bht_o,
    output logic             bob_chwe_o,
    output logic             bob_chbrdir_o,
    output logic [PTR_W:0]   bob_count_o,
    output logic             bob_ovf_o,
    output logic             bob_udf_o
);

    typedef struct packed {
        logic [63:0] brpc;
        logic [11:0] bhr;
        logic [9:0]  bht;
        logic        chwe;
        logic        chbrdir;
    } bob_entry_t;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    // Payload RAM carries no reset; the read path masks it while empty.
    bob_entry_t       mem_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [PTR_W:0]   count_q;
    logic             ovf_q;
    logic             udf_q;

    logic       full;
    logic       empty;
    logic       alloc_acc;
    logic       pop_acc;
    bob_entry_t alloc_ent;
    bob_entry_t head_ent;

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    // Flush wins over both alloc and pop in the same cycle.
    assign alloc_acc = alloc_vld_i & ~full  & ~pipctl_flush_rt_i;
    assign pop_acc   = rt_pop_i    & ~empty & ~pipctl_flush_rt_i;

    assign alloc_ent = '{brpc:    alloc_brpc_i,
                         bhr:     alloc_bhr_i,
                         bht:     alloc_bht_i,
                         chwe:    alloc_chwe_i,
                         chbrdir: alloc_chbrdir_i};

    // Pointer/occupancy state. Pointers are exactly log2(DEPTH) wide so they
    // wrap on their own; count disambiguates full from empty.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            vld_q   <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            if (pipctl_flush_rt_i) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
                vld_q   <= '0;
            end else begin
                // Alloc and pop never target the same slot: that would need
                // the buffer to be both non-empty and not full at one index.
                if (alloc_acc) begin
                    vld_q[tail_q] <= 1'b1;
                    tail_q        <= tail_q + 1'b1;
                end
                if (pop_acc) begin
                    vld_q[head_q] <= 1'b0;
                    head_q        <= head_q + 1'b1;
                end
                case ({alloc_acc, pop_acc})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
            end
            if (alloc_vld_i & full  & ~pipctl_flush_rt_i) ovf_q <= 1'b1;
            if (rt_pop_i    & empty & ~pipctl_flush_rt_i) udf_q <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (alloc_acc) mem_q[tail_q] <= alloc_ent;
    end

    // Head read is purely combinational, so during a flush cycle the
    // predictor still sees the current head for bhr recovery. A freshly
    // allocated entry only becomes visible after its write edge.
    assign head_ent      = empty ? '0 : mem_q[head_q];

    assign bob_valid_o   = ~empty & vld_q[head_q];
    assign bob_brpc_o    = head_ent.brpc;
    assign bob_bhr_o     = head_ent.bhr;
    assign bob_bht_o     = head_ent.bht;
    assign bob_chwe_o    = head_ent.chwe;
    assign bob_chbrdir_o = head_ent.chbrdir;

    assign alloc_rdy_o   = ~full;
    assign alloc_idx_o   = tail_q;
    assign bob_count_o   = count_q;
    assign bob_ovf_o     = ovf_q;
    assign bob_udf_o     = udf_q;

endmodule
